// File: rtl/reflet_gpio_multi_pkg.sv
// Shared constants for the multi-pin GPIO peripheral: register group
// indices and the helpers that turn (group, byte) into a window offset.
package reflet_gpio_multi_pkg;

   // Register groups, each nb_pins/8 bytes wide, little-endian by pin index
   localparam int GRP_OUT     = 0;  // rw: pad output values
   localparam int GRP_DIR     = 1;  // rw: pad output enables, 1 = drive
   localparam int GRP_IN      = 2;  // ro: synchronised pad values
   localparam int GRP_RISE_EN = 3;  // rw: rising-edge interrupt enables
   localparam int GRP_FALL_EN = 4;  // rw: falling-edge interrupt enables
   localparam int GRP_PENDING = 5;  // rw1c: sticky edge flags

   localparam int NB_GROUPS = 6;

   // Size of the register window in bytes for nb bytes per group
   function automatic int window_size(input int nb);
      return NB_GROUPS * nb;
   endfunction

   // Byte offset of one byte of one group inside the window
   function automatic int reg_offset(input int grp, input int nb, input int byte_idx);
      return grp * nb + byte_idx;
   endfunction

endpackage

// File: rtl/reflet_gpio_multi_sync.sv
// Input conditioning for the GPIO pads: a multi-flop synchroniser per pin,
// a one-cycle delayed copy for edge detection, and an arm counter that
// masks edges until the chain has flushed its reset contents.
module reflet_gpio_sync #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2     // 2..4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gpi_i,
   output logic [WIDTH-1:0] synced_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   // Pins high at reset look like rising edges while the chain fills with
   // real pad values; STAGES+1 cycles covers the chain plus the prev flop.
   localparam int ARM_MAX = STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]             prev_q;
   logic [ARM_W-1:0]             arm_q;
   logic [ARM_W-1:0]             arm_d;
   logic                         armed;

   assign synced_o = sync_q[STAGES-1];
   assign armed    = (arm_q == ARM_W'(ARM_MAX));
   assign arm_d    = armed ? arm_q : arm_q + 1'b1;

   assign rise_o = armed ? (synced_o & ~prev_q) : '0;
   assign fall_o = armed ? (~synced_o & prev_q) : '0;

   // Shift pads through the synchroniser, keep last synced value, run arm counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= '0;
         arm_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge
         // value, so the chain shifts by exactly one stage per clock.
         sync_q <= {sync_q[STAGES-2:0], gpi_i};
         prev_q <= synced_o;
         arm_q  <= arm_d;
      end
   end

endmodule

// File: rtl/reflet_gpio_multi.sv
// Memory-mapped GPIO with nb_pins bidirectional pins on the byte-wide bus.
// Six register groups (OUT, DIR, IN, RISE_EN, FALL_EN, PENDING) are laid
// out back to back from base_addr; reads are combinational, writes land on
// the clock edge, and PENDING is write-1-to-clear with set taking priority.
module reflet_gpio_multi
   import reflet_gpio_multi_pkg::*;
#(
   parameter int                        wordsize       = 16,
   parameter int                        base_addr_size = 16,
   parameter logic [base_addr_size-1:0] base_addr      = 16'hFF00,
   parameter int                        nb_pins        = 16,  // multiple of 8, 8..64
   parameter int                        sync_stages    = 2    // 2..4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic                      interrupt,
   input  logic [base_addr_size-1:0] addr,
   input  logic                      write_en,
   input  logic [wordsize-1:0]       data_in,
   output logic [wordsize-1:0]       data_out,
   input  logic [nb_pins-1:0]        gpi,
   output logic [nb_pins-1:0]        gpo,
   output logic [nb_pins-1:0]        gpo_oe
);

   localparam int NB = nb_pins / 8;
   localparam logic [base_addr_size-1:0] WIN = base_addr_size'(window_size(NB));

   logic [nb_pins-1:0] out_q,     out_d;
   logic [nb_pins-1:0] dir_q,     dir_d;
   logic [nb_pins-1:0] rise_en_q, rise_en_d;
   logic [nb_pins-1:0] fall_en_q, fall_en_d;
   logic [nb_pins-1:0] pending_q, pending_d;
   logic [nb_pins-1:0] clr;

   logic [nb_pins-1:0] synced;
   logic [nb_pins-1:0] rise;
   logic [nb_pins-1:0] fall;

   logic [base_addr_size-1:0] offset;
   logic                      sel;
   logic [7:0]                rd_byte;

   // Only the low byte of the bus carries data
   logic unused_data_hi;
   assign unused_data_hi = ^data_in[wordsize-1:8];

   assign offset = addr - base_addr;
   assign sel    = enable && (addr >= base_addr) && (offset < WIN);

   assign gpo       = out_q;
   assign gpo_oe    = dir_q;
   assign interrupt = |pending_q;

   reflet_gpio_sync #(
      .WIDTH  (nb_pins),
      .STAGES (sync_stages)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .gpi_i    (gpi),
      .synced_o (synced),
      .rise_o   (rise),
      .fall_o   (fall)
   );

   // Decode bus writes into next-state values and merge edges into PENDING
   always_comb begin
      // NOTE: every output gets a default before any condition, so no path
      // leaves a variable unassigned and no latch is inferred.
      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (sel && write_en) begin
         for (int b = 0; b < NB; b++) begin
            if (offset == base_addr_size'(reg_offset(GRP_OUT, NB, b)))
               out_d[b*8 +: 8] = data_in[7:0];
            if (offset == base_addr_size'(reg_offset(GRP_DIR, NB, b)))
               dir_d[b*8 +: 8] = data_in[7:0];
            if (offset == base_addr_size'(reg_offset(GRP_RISE_EN, NB, b)))
               rise_en_d[b*8 +: 8] = data_in[7:0];
            if (offset == base_addr_size'(reg_offset(GRP_FALL_EN, NB, b)))
               fall_en_d[b*8 +: 8] = data_in[7:0];
            if (offset == base_addr_size'(reg_offset(GRP_PENDING, NB, b)))
               clr[b*8 +: 8] = data_in[7:0];
         end
      end
      // Set terms are OR-ed after the clear, so a same-cycle edge wins
      pending_d = (pending_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   // Combinational read mux; IN is the synchronised pad value (loopback)
   always_comb begin
      rd_byte = 8'h00;
      if (sel) begin
         for (int b = 0; b < NB; b++) begin
            if (offset == base_addr_size'(reg_offset(GRP_OUT, NB, b)))
               rd_byte = out_q[b*8 +: 8];
            if (offset == base_addr_size'(reg_offset(GRP_DIR, NB, b)))
               rd_byte = dir_q[b*8 +: 8];
            if (offset == base_addr_size'(reg_offset(GRP_IN, NB, b)))
               rd_byte = synced[b*8 +: 8];
            if (offset == base_addr_size'(reg_offset(GRP_RISE_EN, NB, b)))
               rd_byte = rise_en_q[b*8 +: 8];
            if (offset == base_addr_size'(reg_offset(GRP_FALL_EN, NB, b)))
               rd_byte = fall_en_q[b*8 +: 8];
            if (offset == base_addr_size'(reg_offset(GRP_PENDING, NB, b)))
               rd_byte = pending_q[b*8 +: 8];
         end
      end
   end

   // Zero-extend the selected byte onto the bus
   always_comb begin
      data_out      = '0;
      data_out[7:0] = rd_byte;
   end

   // Register file state; asynchronous reset clears everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pending_q <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_reflet_gpio_multi.sv
// Bench for reflet_gpio_multi: a 16-pin and a 32-pin instance share the
// bus signals and have separate enables. Register accesses come from a
// vector table; edge, collision and reset corner cases are hand sequenced.
module tb_reflet_gpio_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        en16, en32;
   logic [15:0] addr;
   logic        write_en;
   logic [15:0] data_in;

   logic [15:0] gpi16, gpo16, gpo_oe16, data_out16;
   logic        irq16;
   logic [31:0] gpi32, gpo32, gpo_oe32;
   logic [15:0] data_out32;
   logic        irq32;

   always #5 clk = ~clk;

   reflet_gpio_multi #(
      .wordsize(16), .base_addr_size(16), .base_addr(16'hFF00),
      .nb_pins(16), .sync_stages(2)
   ) dut16 (
      .clk(clk), .reset(reset), .enable(en16), .interrupt(irq16),
      .addr(addr), .write_en(write_en), .data_in(data_in), .data_out(data_out16),
      .gpi(gpi16), .gpo(gpo16), .gpo_oe(gpo_oe16)
   );

   reflet_gpio_multi #(
      .wordsize(16), .base_addr_size(16), .base_addr(16'hFF00),
      .nb_pins(32), .sync_stages(2)
   ) dut32 (
      .clk(clk), .reset(reset), .enable(en32), .interrupt(irq32),
      .addr(addr), .write_en(write_en), .data_in(data_in), .data_out(data_out32),
      .gpi(gpi32), .gpo(gpo32), .gpo_oe(gpo_oe32)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard: expected read data queued at issue, popped at sample time
   typedef struct {
      string      name;
      logic [7:0] exp;
   } sb_item_t;
   sb_item_t sb_q[$];

   task automatic bus_write(input bit to32, input bit en, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      en16     = en & ~to32;
      en32     = en & to32;
      addr     = a;
      data_in  = {8'h00, d};
      write_en = 1'b1;
      @(posedge clk);
      #1;
      en16     = 1'b0;
      en32     = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic bus_read(input bit to32, input bit en, input logic [15:0] a,
                           input logic [7:0] exp, input string name);
      sb_item_t    it;
      logic [15:0] got;
      @(negedge clk);
      it.name = name;
      it.exp  = exp;
      sb_q.push_back(it);
      en16     = en & ~to32;
      en32     = en & to32;
      addr     = a;
      write_en = 1'b0;
      #1;
      got = to32 ? data_out32 : data_out16;
      it  = sb_q.pop_front();
      check(it.name, got, {8'h00, it.exp});
      en16 = 1'b0;
      en32 = 1'b0;
   endtask

   typedef struct {
      bit          is_wr;
      bit          en;
      logic [15:0] addr;
      logic [7:0]  data;   // write data, or expected read data
      string       name;
   } vec_t;
   vec_t vecs[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 16'hFF00, 8'hA5, "wr out0"};
      vecs[1]  = '{1'b1, 1'b1, 16'hFF01, 8'h3C, "wr out1"};
      vecs[2]  = '{1'b1, 1'b1, 16'hFF02, 8'hFF, "wr dir0"};
      vecs[3]  = '{1'b1, 1'b1, 16'hFF03, 8'h00, "wr dir1"};
      vecs[4]  = '{1'b0, 1'b1, 16'hFF00, 8'hA5, "rd out0"};
      vecs[5]  = '{1'b0, 1'b1, 16'hFF01, 8'h3C, "rd out1"};
      vecs[6]  = '{1'b0, 1'b1, 16'hFF02, 8'hFF, "rd dir0"};
      vecs[7]  = '{1'b0, 1'b1, 16'hFF03, 8'h00, "rd dir1"};
      vecs[8]  = '{1'b1, 1'b1, 16'hFF04, 8'h00, "wr in0 ignored"};
      vecs[9]  = '{1'b0, 1'b1, 16'hFF04, 8'hFF, "rd in0"};
      vecs[10] = '{1'b0, 1'b1, 16'hFF05, 8'hFF, "rd in1"};
      vecs[11] = '{1'b0, 1'b1, 16'hFF07, 8'hFF, "rd rise_en1"};
      vecs[12] = '{1'b0, 1'b1, 16'hFF0C, 8'h00, "rd past window"};
      vecs[13] = '{1'b0, 1'b1, 16'hFEFF, 8'h00, "rd below base"};
      vecs[14] = '{1'b1, 1'b0, 16'hFF00, 8'h55, "wr out0 disabled"};
      vecs[15] = '{1'b0, 1'b0, 16'hFF00, 8'h00, "rd disabled"};

      reset = 1'b1; en16 = 1'b0; en32 = 1'b0; addr = '0; write_en = 1'b0; data_in = '0;
      gpi16 = 16'hFFFF; gpi32 = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset gpo", gpo16, 16'h0000);
      check("reset gpo_oe", gpo_oe16, 16'h0000);
      check("reset irq16", irq16, 1'b0);
      check("reset irq32", irq32, 1'b0);

      // Pins high through reset must not raise false rising edges
      @(negedge clk);
      reset = 1'b0;
      bus_write(1'b0, 1'b1, 16'hFF06, 8'hFF);
      bus_write(1'b0, 1'b1, 16'hFF07, 8'hFF);
      repeat (4) @(posedge clk);
      bus_read(1'b0, 1'b1, 16'hFF04, 8'hFF, "in0 after reset");
      bus_read(1'b0, 1'b1, 16'hFF05, 8'hFF, "in1 after reset");
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h00, "no false pend0");
      bus_read(1'b0, 1'b1, 16'hFF0B, 8'h00, "no false pend1");
      check("no false irq", irq16, 1'b0);

      // Register table
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].is_wr) bus_write(1'b0, vecs[i].en, vecs[i].addr, vecs[i].data);
         else               bus_read(1'b0, vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].name);
      end
      bus_read(1'b0, 1'b1, 16'hFF00, 8'hA5, "out0 after disabled wr");
      check("gpo value", gpo16, 16'h3CA5);
      check("gpo_oe value", gpo_oe16, 16'h00FF);

      // Rising edge on pin 3, exact latency; pin 4 not enabled
      bus_write(1'b0, 1'b1, 16'hFF06, 8'h08);
      bus_write(1'b0, 1'b1, 16'hFF07, 8'h00);
      @(negedge clk);
      gpi16 = 16'h0000;
      repeat (5) @(posedge clk);
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h00, "no pend on fall0");
      bus_read(1'b0, 1'b1, 16'hFF0B, 8'h00, "no pend on fall1");
      @(negedge clk);
      gpi16[3] = 1'b1;
      @(posedge clk);               // first capture
      @(posedge clk);
      #1;
      check("irq at k+1", irq16, 1'b0);
      @(posedge clk);
      #1;
      check("irq at k+2", irq16, 1'b1);
      bus_read(1'b0, 1'b1, 16'hFF04, 8'h08, "in0 pin3");
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h08, "pend pin3");
      @(negedge clk);
      gpi16[4] = 1'b1;
      repeat (5) @(posedge clk);
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h08, "no pend pin4");
      bus_write(1'b0, 1'b1, 16'hFF0A, 8'h08);
      check("irq after w1c", irq16, 1'b0);

      // Falling edge on pin 9, w1c with 00 and 02
      @(negedge clk);
      gpi16[9] = 1'b1;
      repeat (5) @(posedge clk);
      bus_write(1'b0, 1'b1, 16'hFF09, 8'h02);
      @(negedge clk);
      gpi16[9] = 1'b0;
      repeat (5) @(posedge clk);
      bus_read(1'b0, 1'b1, 16'hFF0B, 8'h02, "pend pin9");
      check("irq pin9", irq16, 1'b1);
      bus_write(1'b0, 1'b1, 16'hFF0B, 8'h00);
      bus_read(1'b0, 1'b1, 16'hFF0B, 8'h02, "w1c zero keeps");
      bus_write(1'b0, 1'b1, 16'hFF0B, 8'h02);
      check("irq pin9 cleared", irq16, 1'b0);
      bus_read(1'b0, 1'b1, 16'hFF0B, 8'h00, "pend1 cleared");

      // Clear and new rise on pin 3 in the same cycle: set wins
      @(negedge clk);
      gpi16[3] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      gpi16[3] = 1'b1;
      repeat (5) @(posedge clk);
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h08, "pend3 preset");
      @(negedge clk);
      gpi16[3] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      gpi16[3] = 1'b1;
      @(posedge clk);               // first capture, edge k
      @(posedge clk);               // k+1
      bus_write(1'b0, 1'b1, 16'hFF0A, 8'h08);   // lands on k+2 with the rise
      check("irq set wins", irq16, 1'b1);
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h08, "pend3 set wins");
      bus_write(1'b0, 1'b1, 16'hFF0A, 8'h08);
      bus_read(1'b0, 1'b1, 16'hFF0A, 8'h00, "pend3 cleared");

      // 32-pin instance: window edge and async reset while pending
      bus_write(1'b1, 1'b1, 16'hFF0F, 8'h01);
      @(negedge clk);
      gpi32[24] = 1'b1;
      repeat (5) @(posedge clk);
      bus_read(1'b1, 1'b1, 16'hFF0B, 8'h01, "in32 byte3");
      bus_read(1'b1, 1'b1, 16'hFF17, 8'h01, "pend32 byte3");
      check("irq32 pin24", irq32, 1'b1);
      bus_read(1'b1, 1'b1, 16'hFF18, 8'h00, "rd32 past window");
      bus_write(1'b1, 1'b1, 16'hFF18, 8'hFF);
      bus_read(1'b1, 1'b1, 16'hFF17, 8'h01, "pend32 after oob wr");
      bus_read(1'b1, 1'b1, 16'hFF00, 8'h00, "out32 after oob wr");
      check("gpo32 after oob wr", gpo32, 32'h0);
      check("gpo_oe32 after oob wr", gpo_oe32, 32'h0);

      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("irq32 async reset", irq32, 1'b0);
      check("gpo16 async reset", gpo16, 16'h0000);
      check("gpo_oe16 async reset", gpo_oe16, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      bus_read(1'b1, 1'b1, 16'hFF17, 8'h00, "pend32 after reset");
      check("irq32 after reset", irq32, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reflet_gpio_multi.md
Name: reflet_gpio_multi

Overview:
Parametrised successor to the 16-in/16-out GPIO peripheral. It provides nb_pins bidirectional pins with per-pin direction, input synchronisers and sticky per-pin edge interrupts with write-1-to-clear. It sits on the byte-wide system bus as a memory-mapped peripheral and drives one interrupt line to the interrupt controller.

Parameters:
wordsize, 16, system bus data width; only bits [7:0] are used.
base_addr_size, 16, address bus width.
base_addr, 16'hFF00, first byte of the register window.
nb_pins, 16, number of GPIO pins; multiple of 8, range 8..64.
sync_stages, 2, input synchroniser depth; range 2..4.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  bus access enable
interrupt  out  1  high while any pending bit is set
addr  in  base_addr_size  byte address
write_en  in  1  write strobe
data_in  in  wordsize  write data; [7:0] used
data_out  out  wordsize  read data; upper bits 0
gpi  in  nb_pins  pad inputs, asynchronous
gpo  out  nb_pins  pad output values
gpo_oe  out  nb_pins  pad output enables; 1 = drive

Behaviour:
- NB = nb_pins/8. There are 6 register groups, each NB bytes, little-endian by pin index. Byte address = base_addr + group*NB + byte.
- Groups: 0 OUT (rw), 1 DIR (rw), 2 IN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 PENDING (rw1c).
- sel = enable && addr >= base_addr && addr < base_addr + 6*NB.
- Reads are combinational. data_out = selected byte, zero-extended. data_out = 0 when not sel.
- Writes take effect on posedge clk when sel && write_en.
  - Writes to IN are ignored.
  - A PENDING write clears the bits where data_in is 1.
- gpo = OUT and gpo_oe = DIR, both straight from registers with no extra latency.
- Synchroniser: sync_stages flops per pin. IN returns the synchronised value of every pin, including output pins (loopback).
- Edge detect: prev <= synced every cycle. rise = synced & ~prev; fall = ~synced & prev.
- Pending: pending <= (pending & ~clr) | (rise & RISE_EN) | (fall & FALL_EN).
  - If a clear and a set hit the same bit in the same cycle, the set wins.
- interrupt = |pending, combinational from flops.
- Latency: a gpi change sampled at edge k is visible in IN after edge k+sync_stages-1. It sets pending at edge k+sync_stages; for sync_stages=2, interrupt is high 2 cycles after first capture.
- Arm counter:
  - After reset deassertion, a counter counts sync_stages+1 cycles. Edge detection is masked until it saturates.
  - This prevents pins that are high at reset from raising false rising edges.
  - The counter then holds until the next reset.
- Reset (async, high): OUT, DIR, RISE_EN, FALL_EN, PENDING, synchronisers, prev and arm counter all go to 0.
  - gpo = 0, gpo_oe = 0, interrupt = 0.
- Reset asserted mid-operation clears everything immediately, including pending interrupts.
- Disabling a RISE_EN/FALL_EN bit does not clear an already-pending bit.

Decomposition:
- Shared include file holds:
  - group index localparams (GRP_OUT=0 .. GRP_PENDING=5);
  - NB_GROUPS=6;
  - window size macro (6*NB).
- One sub-module, reflet_gpio_sync, parametrised by width and stages. It contains the synchroniser chain, the prev register and the arm counter, and outputs synced, rise and fall.

Test Plan:
- Reset with gpi=16'hFFFF held -> IN reads FF,FF after 2 cycles; with RISE_EN=FFFF, PENDING stays 0 and interrupt stays 0.
- Write OUT bytes A5,3C and DIR FF,00 -> gpo=16'h3CA5, gpo_oe=16'h00FF; read-back of OUT/DIR matches; write to IN leaves IN unchanged.
- RISE_EN[3]=1, gpi[3] 0->1 -> PENDING[3]=1 and interrupt=1 exactly sync_stages cycles after first capture; gpi[4] rise with RISE_EN[4]=0 -> no pending.
- FALL_EN[9]=1, gpi[9] 1->0 -> PENDING byte1=02; write 02 to PENDING byte1 -> interrupt drops the next cycle; writing 00 clears nothing.
- w1c of PENDING[3] in the same cycle as a new rise on pin 3 -> PENDING[3] stays 1.
- nb_pins=32: address base+23 (PENDING byte3) is valid; base+24 reads 0 and a write there has no effect; async reset mid-pending -> interrupt=0 immediately.
